ps2_key_decoder: RTL and testbench

- Upstream stage of the key-to-colour/type mapper. Consumes raw PS/2 Set-2 bytes from the PS/2 byte receiver and produces the `key_data`/`key_valid` pair the mapper consumes.
- Tracks make/break and E0-extended prefixes.
- Maintains a 24-key held bitmap.
- Selects which held key is reported.

---
 rtl/ps2_key_decoder.sv | 156 +++++++++++++++
 tb/tb_ps2_key_decoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scan-code decoder: make/break/E0 tracking, 24-key held bitmap, reported-key select.
// Build option KEYDEC_REPEAT_EN: typematic repeats of a held key re-assert key_data and pulse key_valid.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
  parameter logic [5:0]  NO_KEY         = 6'h3F
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rx_err,
  input  logic        clear_all,
  output logic [5:0]  key_data,
  output logic        key_valid,
  output logic [23:0] key_held
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [23:0]        r_key_held, w_held_nxt, w_held_brk;
  logic [5:0]         r_key_data, w_data_nxt;
  logic               r_key_valid, w_valid_nxt;
  logic               w_hit;
  logic [5:0]         w_idx;

  // Set-2 make code to note index; bit 6 flags a mapped code.
  function automatic logic [6:0] map_code(input logic [7:0] b);
    case (b)
      8'h1C: map_code = {1'b1, 6'd0};
      8'h1B: map_code = {1'b1, 6'd1};
      8'h23: map_code = {1'b1, 6'd2};
      8'h2B: map_code = {1'b1, 6'd3};
      8'h34: map_code = {1'b1, 6'd4};
      8'h33: map_code = {1'b1, 6'd5};
      8'h3B: map_code = {1'b1, 6'd6};
      8'h1D: map_code = {1'b1, 6'd7};
      8'h24: map_code = {1'b1, 6'd8};
      8'h2C: map_code = {1'b1, 6'd9};
      8'h35: map_code = {1'b1, 6'd10};
      8'h3C: map_code = {1'b1, 6'd11};
      8'h42: map_code = {1'b1, 6'd12};
      8'h4B: map_code = {1'b1, 6'd13};
      8'h4C: map_code = {1'b1, 6'd14};
      8'h52: map_code = {1'b1, 6'd15};
      8'h1A: map_code = {1'b1, 6'd16};
      8'h22: map_code = {1'b1, 6'd17};
      8'h21: map_code = {1'b1, 6'd18};
      8'h44: map_code = {1'b1, 6'd19};
      8'h4D: map_code = {1'b1, 6'd20};
      8'h5B: map_code = {1'b1, 6'd21};
      8'h16: map_code = {1'b1, 6'd22};
      8'h1E: map_code = {1'b1, 6'd23};
      default: map_code = {1'b0, 6'd0};
    endcase
  endfunction

  // Lowest held index, or NO_KEY when the bitmap is empty.
  function automatic logic [5:0] lowest_idx(input logic [23:0] h);
    lowest_idx = NO_KEY;
    for (int i = 23; i >= 0; i--) begin
      if (h[i]) lowest_idx = 6'(i);
    end
  endfunction

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_key_held  <= '0;
      r_key_data  <= NO_KEY;
      r_key_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_key_held  <= w_held_nxt;
      r_key_data  <= w_data_nxt;
      r_key_valid <= w_valid_nxt;
    end
  end

  // Priority: clear_all, then rx_err, then rx_valid, then prefix timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_held_nxt  = r_key_held;
    w_data_nxt  = r_key_data;
    w_valid_nxt = 1'b0;
    {w_hit, w_idx} = map_code(rx_byte);
    w_held_brk  = r_key_held & ~(24'(1) << w_idx);

    if (clear_all) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_held_nxt  = '0;
      w_data_nxt  = NO_KEY;
      w_valid_nxt = (r_key_data != NO_KEY);
    end else if (rx_err) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else if (rx_valid) begin
      w_cnt_nxt = '0;
      case (r_state)
        S_IDLE: begin
          if (rx_byte == 8'hF0) begin
            w_state_nxt = S_BRK;
          end else if (rx_byte == 8'hE0) begin
            w_state_nxt = S_EXT;
          end else if (w_hit) begin
            if (!r_key_held[w_idx]) begin
              w_held_nxt[w_idx] = 1'b1;
              w_data_nxt  = w_idx;
              w_valid_nxt = 1'b1;
            end else begin
`ifdef KEYDEC_REPEAT_EN
              w_data_nxt  = w_idx;
              w_valid_nxt = 1'b1;
`else
              w_data_nxt  = r_key_data;
`endif
            end
          end
        end
        S_BRK: begin
          w_state_nxt = S_IDLE;
          if (w_hit) begin
            w_held_nxt = w_held_brk;
            if (r_key_data == w_idx) begin
              w_data_nxt  = lowest_idx(w_held_brk);
              w_valid_nxt = 1'b1;
            end
          end
        end
        S_EXT:     w_state_nxt = (rx_byte == 8'hF0) ? S_EXT_BRK : S_IDLE;
        S_EXT_BRK: w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end else if (r_state != S_IDLE) begin
      if (r_cnt == CNT_LAST) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  assign key_data  = r_key_data;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed vector table, corner sequences, randomized model check.
module tb_ps2_key_decoder;

  localparam int unsigned TO = 100;
  localparam logic [5:0]  NK = 6'h3F;
`ifdef KEYDEC_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic [7:0]  rx_byte;
  logic        rx_valid, rx_err, clear_all;
  logic [5:0]  key_data;
  logic        key_valid;
  logic [23:0] key_held;

  int n_tests = 0;
  int n_fail  = 0;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .NO_KEY(NK)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .clear_all(clear_all),
    .key_data (key_data),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [7:0]  b;
    logic        v, e, c;
    logic [5:0]  d;
    logic        kv;
    logic [23:0] h;
  } vec_t;
  vec_t vecs[$];

  logic [7:0] codes [24];

  // Reference model state
  int          mmap [256];
  logic [23:0] m_held;
  logic [5:0]  m_data;
  logic        m_valid;
  int          m_pend;   // 0 none, 1 after F0, 2 after E0, 3 after E0 F0
  int          m_idle;

  function automatic void add(input logic [7:0] b, input logic v, input logic e, input logic c,
                              input logic [5:0] d, input logic kv, input logic [23:0] h);
    vec_t t;
    t.b = b; t.v = v; t.e = e; t.c = c; t.d = d; t.kv = kv; t.h = h;
    vecs.push_back(t);
  endfunction

  task automatic cyc(input logic [7:0] b, input logic v, input logic e, input logic c);
    @(negedge CLOCK_50);
    rx_byte = b; rx_valid = v; rx_err = e; clear_all = c;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string name, input logic [5:0] d, input logic kv, input logic [23:0] h);
    n_tests++;
    if (key_data !== d || key_valid !== kv || key_held !== h) begin
      n_fail++;
      $display("FAIL %s: got data=%h valid=%b held=%h, expected data=%h valid=%b held=%h",
               name, key_data, key_valid, key_held, d, kv, h);
    end
  endtask

  function automatic void m_reset();
    m_held = '0; m_data = NK; m_valid = 1'b0; m_pend = 0; m_idle = 0;
  endfunction

  function automatic void m_step(input logic [7:0] b, input logic v, input logic e, input logic c);
    int idx;
    m_valid = 1'b0;
    idx = mmap[b];
    if (c) begin
      m_valid = (m_data != NK);
      m_held = '0; m_data = NK; m_pend = 0; m_idle = 0;
    end else if (e) begin
      m_pend = 0; m_idle = 0;
    end else if (v) begin
      m_idle = 0;
      if (m_pend == 0) begin
        if (b == 8'hF0) m_pend = 1;
        else if (b == 8'hE0) m_pend = 2;
        else if (idx >= 0) begin
          if (!m_held[idx]) begin
            m_held[idx] = 1'b1; m_data = 6'(idx); m_valid = 1'b1;
          end else if (REP) begin
            m_data = 6'(idx); m_valid = 1'b1;
          end
        end
      end else if (m_pend == 1) begin
        m_pend = 0;
        if (idx >= 0) begin
          m_held[idx] = 1'b0;
          if (int'(m_data) == idx) begin
            m_data = NK;
            for (int k = 23; k >= 0; k--) if (m_held[k]) m_data = 6'(k);
            m_valid = 1'b1;
          end
        end
      end else if (m_pend == 2) begin
        m_pend = (b == 8'hF0) ? 3 : 0;
      end else begin
        m_pend = 0;
      end
    end else if (m_pend != 0) begin
      if (m_idle == int'(TO) - 1) begin
        m_pend = 0; m_idle = 0;
      end else begin
        m_idle++;
      end
    end
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    codes = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h1D, 8'h24, 8'h2C, 8'h35, 8'h3C,
              8'h42, 8'h4B, 8'h4C, 8'h52, 8'h1A, 8'h22, 8'h21, 8'h44, 8'h4D, 8'h5B, 8'h16, 8'h1E};
    for (int i = 0; i < 256; i++) mmap[i] = -1;
    for (int i = 0; i < 24; i++) mmap[codes[i]] = i;

    // Directed table: byte, valid, err, clear -> data, valid, held
    add(8'h1C, 1, 0, 0, 6'd0,  1, 24'h000001);
    add(8'hF0, 1, 0, 0, 6'd0,  0, 24'h000001);
    add(8'h1C, 1, 0, 0, NK,    1, 24'h000000);
    add(8'h1B, 1, 0, 0, 6'd1,  1, 24'h000002);
    add(8'h2C, 1, 0, 0, 6'd9,  1, 24'h000202);
    add(8'hF0, 1, 0, 0, 6'd9,  0, 24'h000202);
    add(8'h2C, 1, 0, 0, 6'd1,  1, 24'h000002);
    add(8'h2C, 1, 0, 0, 6'd9,  1, 24'h000202);
    add(8'hF0, 1, 0, 0, 6'd9,  0, 24'h000202);
    add(8'h1B, 1, 0, 0, 6'd9,  0, 24'h000200);
    add(8'hF0, 1, 0, 0, 6'd9,  0, 24'h000200);
    add(8'h2C, 1, 0, 0, NK,    1, 24'h000000);
    add(8'h23, 1, 0, 0, 6'd2,  1, 24'h000004);
    add(8'h23, 1, 0, 0, 6'd2,  REP, 24'h000004);
    add(8'h23, 1, 0, 0, 6'd2,  REP, 24'h000004);
    add(8'hE0, 1, 0, 0, 6'd2,  0, 24'h000004);
    add(8'h1C, 1, 0, 0, 6'd2,  0, 24'h000004);
    add(8'hE0, 1, 0, 0, 6'd2,  0, 24'h000004);
    add(8'hF0, 1, 0, 0, 6'd2,  0, 24'h000004);
    add(8'h23, 1, 0, 0, 6'd2,  0, 24'h000004);
    add(8'h42, 1, 0, 0, 6'd12, 1, 24'h001004);
    add(8'h1C, 1, 0, 1, NK,    1, 24'h000000);
    add(8'h00, 0, 0, 1, NK,    0, 24'h000000);
    add(8'h1C, 1, 1, 0, NK,    0, 24'h000000);
    add(8'hF0, 1, 0, 0, NK,    0, 24'h000000);
    add(8'h00, 0, 1, 0, NK,    0, 24'h000000);
    add(8'h1C, 1, 0, 0, 6'd0,  1, 24'h000001);
    add(8'h00, 0, 0, 0, 6'd0,  0, 24'h000001);
    add(8'h55, 1, 0, 0, 6'd0,  0, 24'h000001);
    add(8'hF0, 1, 0, 0, 6'd0,  0, 24'h000001);
    add(8'h1C, 1, 0, 0, NK,    1, 24'h000000);

    rx_byte = '0; rx_valid = 0; rx_err = 0; clear_all = 0;
    resetn = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("reset_state", NK, 0, 24'h0);
    @(negedge CLOCK_50);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      cyc(vecs[i].b, vecs[i].v, vecs[i].e, vecs[i].c);
      chk($sformatf("vec%0d", i), vecs[i].d, vecs[i].kv, vecs[i].h);
    end

    // Pending break abandoned after the timeout: next 1C is a make
    cyc(8'hF0, 1, 0, 0);
    repeat (TO) cyc(8'h00, 0, 0, 0);
    chk("timeout_idle", NK, 0, 24'h0);
    cyc(8'h1C, 1, 0, 0);
    chk("timeout_make", 6'd0, 1, 24'h000001);

    // Well within the timeout the break is still pending
    cyc(8'hF0, 1, 0, 0);
    repeat (TO / 2) cyc(8'h00, 0, 0, 0);
    cyc(8'h1C, 1, 0, 0);
    chk("prefix_kept_break", NK, 1, 24'h0);

    // Asynchronous reset mid-sequence, checked between clock edges
    cyc(8'h1C, 1, 0, 0);
    chk("pre_async_make", 6'd0, 1, 24'h000001);
    cyc(8'hF0, 1, 0, 0);
    @(negedge CLOCK_50);
    rx_valid = 0;
    #2 resetn = 1'b0;
    #1 chk("async_reset", NK, 0, 24'h0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    cyc(8'h1C, 1, 0, 0);
    chk("post_reset_make", 6'd0, 1, 24'h000001);

    // Randomized run against the reference model
    @(negedge CLOCK_50);
    resetn = 1'b0;
    rx_valid = 0; rx_err = 0; clear_all = 0;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] b;
      logic v, e, c;
      int r;
      r = $urandom_range(0, 11);
      if (r < 2)       b = 8'hF0;
      else if (r == 2) b = 8'hE0;
      else if (r == 3) b = 8'($urandom);
      else if (r < 9)  b = codes[$urandom_range(0, 5)];
      else             b = codes[$urandom_range(0, 23)];
      v = ($urandom_range(0, 2) != 0);
      e = ($urandom_range(0, 40) == 0);
      c = ($urandom_range(0, 80) == 0);
      cyc(b, v, e, c);
      m_step(b, v, e, c);
      chk($sformatf("rand%0d", n), m_data, m_valid, m_held);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
